// File: rtl/branch_predictor_pkg.sv
// Shared constants, BTB write modes and counter helpers for the dynamic branch predictor.
package branch_predictor_pkg;

  localparam int unsigned PC_INCR = 4;

  typedef enum logic [2:0] {
    WrNone,
    WrAlloc,
    WrInc,
    WrDec,
    WrInval
  } wr_mode_e;

  function automatic int unsigned cnt_wt(input int unsigned bits);
    return 32'd1 << (bits - 1);
  endfunction

  function automatic int unsigned cnt_wnt(input int unsigned bits);
    return cnt_wt(bits) - 1;
  endfunction

  function automatic int unsigned cnt_max(input int unsigned bits);
    return (32'd1 << bits) - 1;
  endfunction

  function automatic int unsigned sat_inc(input int unsigned val, input int unsigned max);
    return (val >= max) ? max : val + 1;
  endfunction

  function automatic int unsigned sat_dec(input int unsigned val);
    return (val == 0) ? 0 : val - 1;
  endfunction

endpackage

// File: rtl/branch_predictor_btb_table.sv
// BTB storage: one combinational lookup port, one synchronous write port with per-field modes.
module branch_predictor_btb_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRY_NUM  = 16,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned IDX_BITS   = $clog2(ENTRY_NUM),
  parameter int unsigned TAG_BITS   = ADDR_WIDTH - IDX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_BITS-1:0]   rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [ADDR_WIDTH-1:0] rd_target,
  output logic                  rd_taken,
  input  wr_mode_e              wr_mode,
  input  logic [IDX_BITS-1:0]   wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [ADDR_WIDTH-1:0] wr_target,
  output logic                  wr_hit
);

  localparam logic [CNT_BITS-1:0] CntWt  = CNT_BITS'(cnt_wt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] CntWnt = CNT_BITS'(cnt_wnt(CNT_BITS));
  localparam int unsigned         CntMax = cnt_max(CNT_BITS);

  logic                  valid_q  [ENTRY_NUM];
  logic [TAG_BITS-1:0]   tag_q    [ENTRY_NUM];
  logic [ADDR_WIDTH-1:0] target_q [ENTRY_NUM];
  logic [CNT_BITS-1:0]   cnt_q    [ENTRY_NUM];

  always_comb begin
    rd_valid  = valid_q[rd_idx];
    rd_tag    = tag_q[rd_idx];
    rd_target = target_q[rd_idx];
    rd_taken  = cnt_q[rd_idx][CNT_BITS-1];
    wr_hit    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRY_NUM; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CntWnt;
      end
    end else begin
      case (wr_mode)
        WrAlloc: begin
          valid_q[wr_idx] <= 1'b1;
          cnt_q[wr_idx]   <= CntWt;
        end
        WrInc:   cnt_q[wr_idx] <= CNT_BITS'(sat_inc(int'(cnt_q[wr_idx]), CntMax));
        WrDec:   cnt_q[wr_idx] <= CNT_BITS'(sat_dec(int'(cnt_q[wr_idx])));
        WrInval: valid_q[wr_idx] <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag and target are masked by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (!rst && (wr_mode == WrAlloc || wr_mode == WrInc)) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor: BTB lookup, MEM-stage training, mispredict and statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ENTRY_NUM  = 16,
  parameter int unsigned CNT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] lk_pc,
  output logic                  pred_taken,
  output logic [ADDR_WIDTH-1:0] pred_target,
  input  logic                  upd_valid,
  input  logic [ADDR_WIDTH-1:0] upd_pc,
  input  logic                  upd_is_branch,
  input  logic                  upd_taken,
  input  logic [ADDR_WIDTH-1:0] upd_target,
  input  logic                  upd_pred_taken,
  input  logic [ADDR_WIDTH-1:0] upd_pred_target,
  output logic                  mispredict,
  output logic [ADDR_WIDTH-1:0] recover_pc,
  output logic [31:0]           stat_branch_cnt,
  output logic [31:0]           stat_miss_cnt
);

  localparam int unsigned IDX_BITS = $clog2(ENTRY_NUM);
  localparam int unsigned TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;
  localparam logic [ADDR_WIDTH-1:0] Incr = ADDR_WIDTH'(PC_INCR);

  logic [IDX_BITS-1:0]   lk_idx, upd_idx;
  logic [TAG_BITS-1:0]   lk_tag, upd_tag, rd_tag;
  logic [ADDR_WIDTH-1:0] rd_target;
  logic                  rd_valid, rd_taken, wr_hit, lk_hit;
  wr_mode_e              wr_mode;

  // The carried direction bit is redundant with the carried target.
  logic unused_pred_taken;
  assign unused_pred_taken = upd_pred_taken;

  assign lk_idx  = lk_pc[IDX_BITS+1:2];
  assign lk_tag  = lk_pc[ADDR_WIDTH-1:IDX_BITS+2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign upd_tag = upd_pc[ADDR_WIDTH-1:IDX_BITS+2];

  branch_predictor_btb_table #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ENTRY_NUM  (ENTRY_NUM),
    .CNT_BITS   (CNT_BITS)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (lk_idx),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_taken  (rd_taken),
    .wr_mode   (wr_mode),
    .wr_idx    (upd_idx),
    .wr_tag    (upd_tag),
    .wr_target (upd_target),
    .wr_hit    (wr_hit)
  );

  always_comb begin
    lk_hit      = rd_valid && (rd_tag == lk_tag);
    pred_taken  = lk_hit && rd_taken;
    pred_target = pred_taken ? rd_target : lk_pc + Incr;
    recover_pc  = upd_taken ? upd_target : upd_pc + Incr;
    mispredict  = upd_valid && !rst && (upd_pred_target != recover_pc);
  end

  always_comb begin
    wr_mode = WrNone;
    if (upd_valid && !rst) begin
      if (upd_is_branch) begin
        if (wr_hit)         wr_mode = upd_taken ? WrInc : WrDec;
        else if (upd_taken) wr_mode = WrAlloc;
      end else if (wr_hit) begin
        wr_mode = WrInval;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branch_cnt <= '0;
      stat_miss_cnt   <= '0;
    end else begin
      if (upd_valid && upd_is_branch && stat_branch_cnt != '1) begin
        stat_branch_cnt <= stat_branch_cnt + 32'd1;
      end
      if (mispredict && stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lk_pc, upd_pc, upd_target, upd_pred_target;
  logic        upd_valid, upd_is_branch, upd_taken, upd_pred_taken;
  logic        pred_taken, mispredict;
  logic [31:0] pred_target, recover_pc, stat_branch_cnt, stat_miss_cnt;

  always #5 clk = ~clk;

  branch_predictor #(
    .ADDR_WIDTH (32),
    .ENTRY_NUM  (16),
    .CNT_BITS   (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .lk_pc           (lk_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_is_branch   (upd_is_branch),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .recover_pc      (recover_pc),
    .stat_branch_cnt (stat_branch_cnt),
    .stat_miss_cnt   (stat_miss_cnt)
  );

  typedef struct {
    logic        pt;
    logic [31:0] ptgt;
    logic        mp;
    logic [31:0] rpc;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: 16 entries, 2-bit counters (taken when counter >= 2).
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_cnt   [16];
  logic [31:0] m_bc, m_mc;

  function automatic int pc_idx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic logic [31:0] pc_tag(input logic [31:0] pc);
    return pc >> 6;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[pc_idx(pc)] && m_tag[pc_idx(pc)] == pc_tag(pc);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] lk, input logic uv,
                      input logic [31:0] upc, input logic isb, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] ptgt);
    exp_t        e;
    logic [31:0] an;
    int          ui;
    @(posedge clk);
    #1;
    rst = r; lk_pc = lk; upd_valid = uv; upd_pc = upc; upd_is_branch = isb;
    upd_taken = tk; upd_target = tgt; upd_pred_target = ptgt;
    upd_pred_taken = (ptgt != upc + 32'd4);
    e.pt   = m_hit(lk) && m_cnt[pc_idx(lk)] >= 2;
    e.ptgt = e.pt ? m_tgt[pc_idx(lk)] : lk + 32'd4;
    an     = tk ? tgt : upc + 32'd4;
    e.mp   = uv && !r && (ptgt != an);
    e.rpc  = an;
    e.bc   = m_bc;
    e.mc   = m_mc;
    exp_q.push_back(e);
    if (r) begin
      m_reset();
    end else if (uv) begin
      ui = pc_idx(upc);
      if (isb && m_bc != 32'hFFFF_FFFF) m_bc++;
      if (e.mp && m_mc != 32'hFFFF_FFFF) m_mc++;
      if (isb) begin
        if (m_hit(upc)) begin
          if (tk) begin
            m_cnt[ui] = (m_cnt[ui] < 3) ? m_cnt[ui] + 1 : 3;
            m_tgt[ui] = tgt;
          end else begin
            m_cnt[ui] = (m_cnt[ui] > 0) ? m_cnt[ui] - 1 : 0;
          end
        end else if (tk) begin
          m_valid[ui] = 1;
          m_tag[ui]   = pc_tag(upc);
          m_tgt[ui]   = tgt;
          m_cnt[ui]   = 2;
        end
      end else if (m_hit(upc)) begin
        m_valid[ui] = 0;
      end
    end
  endtask

  task automatic look(input logic [31:0] lk);
    step(1'b0, lk, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h4);
  endtask

  // Monitor: compare every presented cycle against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("pred_taken", 32'(pred_taken), 32'(e.pt));
      check("pred_target", pred_target, e.ptgt);
      check("mispredict", 32'(mispredict), 32'(e.mp));
      check("recover_pc", recover_pc, e.rpc);
      check("stat_branch_cnt", stat_branch_cnt, e.bc);
      check("stat_miss_cnt", stat_miss_cnt, e.mc);
    end
  end

  initial begin
    logic [31:0] pc, tgt, an, ptgt;
    logic        tk, isb;
    rst = 1'b1; lk_pc = 0; upd_valid = 0; upd_pc = 0; upd_is_branch = 0;
    upd_taken = 0; upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0;
    repeat (2) @(posedge clk);
    m_reset();

    look(32'h40);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h44);
    look(32'h40);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h44);
    look(32'h40);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h44);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h100);
    look(32'h40);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h100);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h100);
    look(32'h40);
    step(1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1, 32'h200, 32'h84);
    look(32'h40);
    look(32'h80);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h44);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0, 32'h0, 32'h44);
    look(32'h40);
    step(1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h44);
    look(32'h40);
    look(32'hFFFF_FFFC);
    step(1'b1, 32'h40, 1'b1, 32'h40, 1'b1, 1'b1, 32'h100, 32'h44);
    look(32'h40);

    for (int n = 0; n < 600; n++) begin
      pc   = (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 7) == 0) pc = pc | 32'($urandom_range(0, 3));
      isb  = ($urandom_range(0, 5) != 0);
      tk   = isb && ($urandom_range(0, 2) != 0);
      tgt  = 32'($urandom_range(0, 7)) << 8;
      an   = tk ? tgt : pc + 32'd4;
      if ($urandom_range(0, 1) == 1) ptgt = an;
      else ptgt = (m_hit(pc) && m_cnt[pc_idx(pc)] >= 2) ? m_tgt[pc_idx(pc)] : pc + 32'd4;
      step(($urandom_range(0, 49) == 0),
           (32'($urandom_range(1, 3)) << 6) | (32'($urandom_range(0, 3)) << 2),
           ($urandom_range(0, 3) != 0), pc, isb, tk, tgt, ptgt);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor with a branch target buffer, used in the IF stage of the MIPS 5-stage pipelined CPU.
- Successor to static "predict not-taken, resolve in MEM": IF gets a predicted next PC every cycle.
- MEM-stage branch resolution trains the table and raises a mispredict/recover request.
- Parametrised in table depth, PC width and counter width; keeps saturating statistics counters readable through the debug mux.

Parameters:
ADDR_WIDTH, 32, PC width in bits
ENTRY_NUM, 16, BTB entries; power of 2, >= 2; IDX_BITS = log2(ENTRY_NUM)
CNT_BITS, 2, saturating direction-counter width; >= 1

Ports:
clk  in  1  main clock
rst  in  1  synchronous active-high reset
lk_pc  in  ADDR_WIDTH  IF-stage PC to predict
pred_taken  out  1  predicted taken for lk_pc
pred_target  out  ADDR_WIDTH  predicted next PC
upd_valid  in  1  resolved instruction present in MEM this cycle
upd_pc  in  ADDR_WIDTH  PC of resolved instruction
upd_is_branch  in  1  resolved instruction is jump/branch
upd_taken  in  1  actual direction
upd_target  in  ADDR_WIDTH  actual taken target
upd_pred_taken  in  1  prediction carried down the pipe with the instruction
upd_pred_target  in  ADDR_WIDTH  predicted next PC carried down the pipe
mispredict  out  1  flush IF/ID/EXE and redirect
recover_pc  out  ADDR_WIDTH  correct next PC
stat_branch_cnt  out  32  resolved branches
stat_miss_cnt  out  32  mispredictions

Behaviour:
- Index is PC[IDX_BITS+1:2]; tag is PC[ADDR_WIDTH-1:IDX_BITS+2]. PC[1:0] is ignored.
- Each entry holds valid, tag, target[ADDR_WIDTH] and cnt[CNT_BITS].
- Counter encodings:
  - WT (weakly taken) = 1<<(CNT_BITS-1)
  - WNT (weakly not-taken) = WT-1
  - MAX = all ones
  - If CNT_BITS = 1, WNT = 0.
- Lookup is combinational from registered state; zero latency.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && cnt[MSB].
  - pred_target = pred_taken ? target : lk_pc+4. Addition wraps modulo 2^ADDR_WIDTH.
- Mispredict is combinational in the update cycle.
  - actual_next = upd_taken ? upd_target : upd_pc+4.
  - mispredict = upd_valid && !rst && (upd_pred_target != actual_next).
  - recover_pc = actual_next.
  - When mispredict = 0, recover_pc is don't-care but must still be driven as actual_next.
- Table update is registered and visible from the next cycle. It occurs only when upd_valid && !rst.
  - Branch, hit, taken: cnt = min(cnt+1, MAX); target = upd_target.
  - Branch, hit, not-taken: cnt = max(cnt-1, 0); target unchanged.
  - Branch, miss, taken: allocate, overwriting any entry at that index (alias replacement). Set valid=1, tag, target, cnt=WT.
  - Branch, miss, not-taken: no change.
  - Not a branch, hit: clear valid (stale entry).
  - Not a branch, miss: no change.
- Lookup and update in the same cycle at the same index: lookup returns pre-update contents. No bypass.
- Statistics:
  - stat_branch_cnt += 1 on upd_valid && upd_is_branch.
  - stat_miss_cnt += 1 on mispredict.
  - Both saturate at 0xFFFF_FFFF and never wrap.
- Reset (synchronous, any cycle including mid-update):
  - Clears all valid bits, sets all cnt to WNT, clears both statistics counters.
  - An update presented in the reset cycle is discarded.
  - Outputs in the cycle after reset: pred_taken=0, pred_target=lk_pc+4. mispredict=0 during reset.
- Targets and tags need no reset value; valid=0 masks them.

Decomposition:
- Shared package/header (alongside the mips defines):
  - PC_INCR = 4
  - counter encoding helpers WT/WNT/MAX as functions of CNT_BITS
  - saturating-increment/decrement function
- Sub-module btb_table:
  - ENTRY_NUM-deep register array of {valid, tag, target, cnt}
  - one combinational read port, one synchronous write port with per-field write mode (allocate / train / invalidate)
  - synchronous reset of valid and cnt
- branch_predictor contains index/tag split, mispredict logic and statistics.

Test Plan:
1. Reset, then lk_pc=0x0000_0040 -> pred_taken=0, pred_target=0x0000_0044; both stats=0.
2. Update pc=0x40, branch, taken, target=0x100, pred_target=0x44 -> same cycle mispredict=1, recover_pc=0x100; next cycle lookup 0x40 gives pred_taken=1, pred_target=0x100; stat_miss_cnt=1, stat_branch_cnt=1.
3. From case 2 (cnt=10), two not-taken updates at 0x40 with correct pred_target fields:
   - cnt 10->01: lookup not-taken, target 0x44.
   - cnt 01->00.
   - A third taken update gives cnt 01, still predicting not-taken.
   - Two more taken updates saturate cnt at 11.
4. Alias, ENTRY_NUM=16: pc 0x80 has the same index as 0x40 (idx 0) with a different tag. A taken update to 0x80 with target 0x200 replaces the entry; lookup 0x40 -> miss, target 0x44; lookup 0x80 -> taken, target 0x200.
5. Same cycle: lookup 0x40 while a not-taken update at 0x40 takes cnt 10->01 -> that cycle pred_taken=1; next cycle pred_taken=0. Also, a non-branch update at 0x40 invalidates the entry.
6. rst=1 together with a taken upd_valid at 0x40 -> mispredict=0, no allocation, stats stay 0; after release, lookup 0x40 misses.
